// File: rtl/teclado_pin_pkg.sv
// Shared definitions for the keypad front end: one-hot scan states, key codes
// and the row/column to key-code map reused by the PIN receiver.
package teclado_pin_pkg;

  localparam logic [3:0] StEscaneo      = 4'b0001;
  localparam logic [3:0] StRebote       = 4'b0010;
  localparam logic [3:0] StEmitir       = 4'b0100;
  localparam logic [3:0] StEsperaSoltar = 4'b1000;

  localparam logic [3:0] Cod0   = 4'd0;
  localparam logic [3:0] Cod1   = 4'd1;
  localparam logic [3:0] Cod2   = 4'd2;
  localparam logic [3:0] Cod3   = 4'd3;
  localparam logic [3:0] Cod4   = 4'd4;
  localparam logic [3:0] Cod5   = 4'd5;
  localparam logic [3:0] Cod6   = 4'd6;
  localparam logic [3:0] Cod7   = 4'd7;
  localparam logic [3:0] Cod8   = 4'd8;
  localparam logic [3:0] Cod9   = 4'd9;
  localparam logic [3:0] CodA   = 4'hA;
  localparam logic [3:0] CodB   = 4'hB;
  localparam logic [3:0] CodC   = 4'hC;
  localparam logic [3:0] CodD   = 4'hD;
  localparam logic [3:0] CodAst = 4'hE;
  localparam logic [3:0] CodAlm = 4'hF;

  function automatic logic [3:0] codigo_tecla(input logic [1:0] fila, input logic [1:0] col);
    logic [3:0] cod;
    case ({fila, col})
      4'b00_00: cod = Cod1;
      4'b00_01: cod = Cod2;
      4'b00_10: cod = Cod3;
      4'b00_11: cod = CodA;
      4'b01_00: cod = Cod4;
      4'b01_01: cod = Cod5;
      4'b01_10: cod = Cod6;
      4'b01_11: cod = CodB;
      4'b10_00: cod = Cod7;
      4'b10_01: cod = Cod8;
      4'b10_10: cod = Cod9;
      4'b10_11: cod = CodC;
      4'b11_00: cod = CodAst;
      4'b11_01: cod = Cod0;
      4'b11_10: cod = CodAlm;
      default:  cod = CodD;
    endcase
    return cod;
  endfunction

  function automatic logic es_digito(input logic [3:0] cod);
    return (cod <= Cod9);
  endfunction

endpackage

// File: rtl/teclado_pin_sincronizador_filas.sv
// Two-flop synchronizer for the asynchronous keypad rows; idles at all-high
// (no key) so reset never looks like a press.
module teclado_pin_sincronizador_filas (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/teclado_pin.sv
// 4x4 keypad scanner with press/release debounce; emits one digit strobe or
// one invalid-key pulse per accepted press.
module teclado_pin
  import teclado_pin_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       habilitar,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [3:0] digito,
  output logic       digito_stb,
  output logic       tecla_invalida
);

  localparam int unsigned DwW  = $clog2(SCAN_CYCLES + 1);
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DwW-1:0]  DwellLast = DwW'(SCAN_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax    = CntW'(DEBOUNCE_CYCLES);

  logic [3:0]      fs;
  logic [3:0]      state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [DwW-1:0]  dwell_q, dwell_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]      fila_q, fila_d;
  logic [3:0]      digito_q, digito_d;
  logic            stb_q, stb_d;
  logic            inv_q, inv_d;
  logic [1:0]      fila_baja;
  logic [3:0]      codigo;

  teclado_pin_sincronizador_filas u_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (filas),
    .q_o    (fs)
  );

  // Lowest low row wins when several keys share the scanned column.
  always_comb begin
    fila_baja = 2'd0;
    if      (!fs[0]) fila_baja = 2'd0;
    else if (!fs[1]) fila_baja = 2'd1;
    else if (!fs[2]) fila_baja = 2'd2;
    else if (!fs[3]) fila_baja = 2'd3;
  end

  assign codigo  = codigo_tecla(fila_q, col_q);
  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    fila_d   = fila_q;
    digito_d = digito_q;
    stb_d    = 1'b0;
    inv_d    = 1'b0;
    case (state_q)
      StEscaneo: begin
        if (dwell_q == DwellLast) begin
          dwell_d = '0;
          if (fs != 4'hF) begin
            fila_d  = fila_baja;
            cnt_d   = '0;
            state_d = StRebote;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DwW'(1);
        end
      end
      StRebote: begin
        if (!fs[fila_q]) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntMax) begin
            cnt_d   = '0;
            state_d = StEmitir;
          end
        end else begin
          col_d   = col_q + 2'd1;
          dwell_d = '0;
          cnt_d   = '0;
          state_d = StEscaneo;
        end
      end
      StEmitir: begin
        if (habilitar) begin
          if (es_digito(codigo)) begin
            digito_d = codigo;
            stb_d    = 1'b1;
          end else begin
            inv_d = 1'b1;
          end
        end
        cnt_d   = '0;
        state_d = StEsperaSoltar;
      end
      StEsperaSoltar: begin
        if (fs == 4'hF) begin
          if (cnt_inc == CntMax) begin
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            dwell_d = '0;
            state_d = StEscaneo;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        dwell_d = '0;
        cnt_d   = '0;
        state_d = StEscaneo;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StEscaneo;
      col_q    <= 2'd0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      fila_q   <= 2'd0;
      digito_q <= 4'd0;
      stb_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      fila_q   <= fila_d;
      digito_q <= digito_d;
      stb_q    <= stb_d;
      inv_q    <= inv_d;
    end
  end

  assign columnas       = ~(4'b0001 << col_q);
  assign digito         = digito_q;
  assign digito_stb     = stb_q;
  assign tecla_invalida = inv_q;

endmodule
